// File: rtl/core_dispatch.sv
// core_dispatch: fetches tagged 16-bit program words and drives one CPU7 core's instruction,
// push and pcp-step strobes. Long literals (tag 10) exist only with CORE_DISPATCH_LONG_LIT_EN.
module core_dispatch #(
   parameter int ADDR_W = 28
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   output logic              mem_rd_en,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [15:0]       mem_rdata,
   input  logic [27:0]       core_pcp,
   input  logic              acore_idle,
   output logic [55:0]       push_value,
   output logic              push_en,
   output logic [13:0]       instr,
   output logic              instr_en,
   output logic              pcp_step_en,
   output logic              busy,
   output logic              halted,
   output logic              fault
);

   typedef enum logic [2:0] {
      S_IDLE, S_FETCH, S_CAPTURE, S_ISSUE, S_DRAIN, S_HALT
   } state_t;

   localparam logic [1:0] TAG_INSTR = 2'b00;
   localparam logic [1:0] TAG_SHORT = 2'b01;
   localparam logic [1:0] TAG_LONG  = 2'b10;

   // The pending word register doubles as the long-literal shift register when enabled.
`ifdef CORE_DISPATCH_LONG_LIT_EN
   localparam int VAL_W = 56;
`else
   localparam int VAL_W = 14;
`endif

   state_t            state, state_d;
   logic [ADDR_W-1:0] fa;
   logic [2:0]        debt;
   logic [VAL_W-1:0]  word_val, cand_val;
   logic              word_is_instr, cand_is_instr;
   logic              accept, cap, ready, do_issue, step, set_fault;
`ifdef CORE_DISPATCH_LONG_LIT_EN
   logic [2:0]        lit_cnt;
   logic              lit_load, lit_shift;
`endif

   assign mem_rd_en = (state == S_FETCH);
   assign mem_addr  = fa;
   assign busy      = (state != S_IDLE) && (state != S_HALT);
   assign halted    = (state == S_HALT);
   assign accept    = !busy && start;
   assign step      = acore_idle && (debt != 3'd0);

   always_comb begin
      // NOTE: every signal gets a default first so no path can infer a latch.
      state_d       = state;
      cap           = 1'b0;
      ready         = 1'b0;
      set_fault     = 1'b0;
      cand_is_instr = word_is_instr;
      cand_val      = word_val;
`ifdef CORE_DISPATCH_LONG_LIT_EN
      lit_load      = 1'b0;
      lit_shift     = 1'b0;
`endif
      case (state)
         S_IDLE, S_HALT: if (start) state_d = S_FETCH;
         S_FETCH:        state_d = S_CAPTURE;
         S_CAPTURE: begin
            cand_is_instr = (mem_rdata[15:14] == TAG_INSTR);
            cand_val      = VAL_W'(mem_rdata[13:0]);
`ifdef CORE_DISPATCH_LONG_LIT_EN
            if (lit_cnt != 3'd0) begin
               // Payload words ignore their tag; first payload ends up most significant.
               cap           = 1'b1;
               lit_shift     = 1'b1;
               cand_is_instr = 1'b0;
               cand_val      = {word_val[VAL_W-15:0], mem_rdata[13:0]};
               ready         = (lit_cnt == 3'd1);
               state_d       = ready ? S_ISSUE : S_FETCH;
            end else begin
`else
            begin
`endif
               case (mem_rdata[15:14])
                  TAG_INSTR, TAG_SHORT: begin
                     cap     = 1'b1;
                     ready   = 1'b1;
                     state_d = S_ISSUE;
                  end
                  TAG_LONG: begin
`ifdef CORE_DISPATCH_LONG_LIT_EN
                     cap      = 1'b1;
                     lit_load = 1'b1;
                     state_d  = S_FETCH;
`else
                     set_fault = 1'b1;
                     state_d   = S_DRAIN;
`endif
                  end
                  default: state_d = S_DRAIN;
               endcase
            end
         end
         S_ISSUE: ready = 1'b1;
         S_DRAIN: if (debt == 3'd0) state_d = S_HALT;
         default: state_d = S_IDLE;
      endcase
      // A freshly captured word issues in its capture cycle when the core is already idle.
      do_issue = ready && acore_idle && !(instr_en || push_en);
      if (do_issue) state_d = S_FETCH;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= S_IDLE;
         fa            <= '0;
         debt          <= '0;
         word_val      <= '0;
         word_is_instr <= 1'b0;
         fault         <= 1'b0;
         push_value    <= '0;
         push_en       <= 1'b0;
         instr         <= '0;
         instr_en      <= 1'b0;
         pcp_step_en   <= 1'b0;
`ifdef CORE_DISPATCH_LONG_LIT_EN
         lit_cnt       <= '0;
`endif
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         state       <= state_d;
         instr_en    <= 1'b0;
         push_en     <= 1'b0;
         pcp_step_en <= step;
         debt        <= debt + 3'(cap) - 3'(step);
         if (accept)                fa <= core_pcp[ADDR_W-1:0];
         else if (state == S_FETCH) fa <= fa + ADDR_W'(1);
         if (state == S_CAPTURE) begin
            word_val      <= cand_val;
            word_is_instr <= cand_is_instr;
         end
         if (set_fault) fault <= 1'b1;
`ifdef CORE_DISPATCH_LONG_LIT_EN
         if (lit_load)       lit_cnt <= 3'd4;
         else if (lit_shift) lit_cnt <= lit_cnt - 3'd1;
`endif
         if (do_issue) begin
            if (cand_is_instr) begin
               instr    <= cand_val[13:0];
               instr_en <= 1'b1;
            end else begin
               push_value <= 56'(cand_val);
               push_en    <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_core_dispatch.sv
// tb_core_dispatch: directed bench for core_dispatch; a program-level model predicts the fetch
// addresses, dispatch stream and step count, checked every cycle by one compare process.
`timescale 1ns/1ps
module tb_core_dispatch;

   localparam int AW = 4;

   typedef struct {
      logic        is_instr;
      logic [55:0] val;
   } ev_t;

   logic          clk = 1'b0;
   logic          rst, start, acore_idle;
   logic          mem_rd_en, push_en, instr_en, pcp_step_en, busy, halted, fault;
   logic [AW-1:0] mem_addr;
   logic [15:0]   mem_rdata = '0;
   logic [27:0]   core_pcp = '0;
   logic [55:0]   push_value;
   logic [13:0]   instr;

   core_dispatch #(.ADDR_W(AW)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .mem_rd_en  (mem_rd_en),
      .mem_addr   (mem_addr),
      .mem_rdata  (mem_rdata),
      .core_pcp   (core_pcp),
      .acore_idle (acore_idle),
      .push_value (push_value),
      .push_en    (push_en),
      .instr      (instr),
      .instr_en   (instr_en),
      .pcp_step_en(pcp_step_en),
      .busy       (busy),
      .halted     (halted),
      .fault      (fault)
   );

   always #5 clk = ~clk;

   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   int          start_cyc = 0;
   logic [15:0] mem [16];
   logic        pcp_ld = 1'b0;
   logic [27:0] pcp_ld_val = '0;

   logic [AW-1:0] exp_fetch[$];
   ev_t           exp_ev[$];
   int            exp_steps = 0;
   logic          fault_exp = 1'b0;

   int          step_seen = 0, strobe_seen = 0, push_seen = 0, first_strobe_cyc = -1;
   logic [13:0] last_instr = '0;
   logic [55:0] last_push = '0;
   logic        idle_prev = 1'b0, strobe_prev = 1'b0, rd_prev = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Program memory with one-cycle read latency, and the core's pcp register.
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (mem_rd_en) mem_rdata <= mem[mem_addr];
      if (pcp_ld) core_pcp <= pcp_ld_val;
      else if (pcp_step_en) core_pcp <= core_pcp + 28'd1;
   end

   // Compare process: outputs are stable at the falling edge.
   always @(negedge clk) begin
      ev_t e;
      if (mem_rd_en) begin
         check("read_pacing", 64'(rd_prev), 0);
         check("fetch_pending", 64'(exp_fetch.size() != 0), 1);
         if (exp_fetch.size() != 0) check("fetch_addr", mem_addr, exp_fetch.pop_front());
      end
      if (instr_en || push_en) begin
         strobe_seen++;
         if (first_strobe_cyc < 0) first_strobe_cyc = cyc;
         check("strobe_excl", 64'(instr_en & push_en), 0);
         check("strobe_gap", 64'(strobe_prev), 0);
         check("strobe_idle", 64'(idle_prev), 1);
         if (instr_en) last_instr = instr;
         else begin
            last_push = push_value;
            push_seen++;
         end
         check("strobe_pending", 64'(exp_ev.size() != 0), 1);
         if (exp_ev.size() != 0) begin
            e = exp_ev.pop_front();
            check("strobe_kind", 64'(instr_en), 64'(e.is_instr));
            check("strobe_val", instr_en ? 56'(instr) : push_value, e.val);
         end
      end
      if (pcp_step_en) begin
         step_seen++;
         check("step_idle", 64'(idle_prev), 1);
      end
      idle_prev   = acore_idle;
      strobe_prev = instr_en || push_en;
      rd_prev     = mem_rd_en;
   end

   // Walks the program as the core would see it: one dispatch per word, one step per
   // consumed non-halt word, fetch addresses wrapping within the AW-bit space.
   task automatic build_model(input logic [27:0] pcp0);
      logic [AW-1:0] a;
      logic [15:0]   w;
      logic [55:0]   lit;
      ev_t           e;
      bit            done;
      exp_fetch.delete();
      exp_ev.delete();
      exp_steps = 0;
      a    = pcp0[AW-1:0];
      done = 1'b0;
      for (int n = 0; n < 32 && !done; n++) begin
         w = mem[a];
         exp_fetch.push_back(a);
         a = a + 1'b1;
         case (w[15:14])
            2'b00, 2'b01: begin
               e.is_instr = (w[15:14] == 2'b00);
               e.val      = 56'(w[13:0]);
               exp_ev.push_back(e);
               exp_steps++;
            end
            2'b10: begin
`ifdef CORE_DISPATCH_LONG_LIT_EN
               lit = '0;
               for (int k = 0; k < 4; k++) begin
                  w = mem[a];
                  exp_fetch.push_back(a);
                  a   = a + 1'b1;
                  lit = {lit[41:0], w[13:0]};
               end
               e.is_instr = 1'b0;
               e.val      = lit;
               exp_ev.push_back(e);
               exp_steps += 5;
`else
               fault_exp = 1'b1;
               done      = 1'b1;
`endif
            end
            default: done = 1'b1;
         endcase
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic set_pcp(input logic [27:0] v);
      pcp_ld_val = v;
      pcp_ld     = 1'b1;
      tick(1);
      pcp_ld     = 1'b0;
   endtask

   task automatic clear_mem();
      for (int i = 0; i < 16; i++) mem[i] = 16'hC000;
   endtask

   task automatic check_reset_state();
      check("reset_push_value", push_value, 0);
      check("reset_ctrl", {mem_rd_en, mem_addr, push_en, instr, instr_en, pcp_step_en,
                           busy, halted, fault}, 0);
   endtask

   // Runs a program from pcp0 until halt; hold>0 keeps the core busy for that many cycles.
   task automatic run_prog(input logic [27:0] pcp0, input int hold);
      int wait_n;
      int rise_cyc;
      set_pcp(pcp0);
      build_model(pcp0);
      step_seen        = 0;
      strobe_seen      = 0;
      push_seen        = 0;
      first_strobe_cyc = -1;
      rise_cyc         = 0;
      if (hold > 0) acore_idle = 1'b0;
      start     = 1'b1;
      start_cyc = cyc;
      tick(1);
      start = 1'b0;
      if (hold > 0) begin
         tick(hold - 1);
         check("busy_no_strobe", strobe_seen, 0);
         check("busy_no_step", step_seen, 0);
         acore_idle = 1'b1;
         rise_cyc   = cyc;
      end
      wait_n = 0;
      while (!halted && wait_n < 200) begin
         tick(1);
         wait_n++;
      end
      check("halt_reached", halted, 1);
      if (hold > 0) check("busy_release", first_strobe_cyc, rise_cyc + 1);
      check("busy_flag", busy, 0);
      check("events_left", exp_ev.size(), 0);
      check("fetches_left", exp_fetch.size(), 0);
      check("step_count", step_seen, exp_steps);
      check("final_pcp", core_pcp, pcp0 + 28'(exp_steps));
      check("fault", fault, fault_exp);
   endtask

   initial begin
      logic [55:0] lit_ref;
      rst        = 1'b1;
      start      = 1'b0;
      acore_idle = 1'b1;
      clear_mem();
      tick(2);
      check_reset_state();
      rst = 1'b0;
      tick(1);

      // Single instruction followed by halt.
      mem[0] = 16'h0183;
      mem[1] = 16'hC000;
      run_prog(28'd0, 0);
      check("single_latency", first_strobe_cyc, start_cyc + 3);
      check("single_instr", last_instr, 14'h0183);
      check("single_steps", step_seen, 1);
      check("single_pcp", core_pcp, 28'd1);

      // Restart from HALT lands on the same halt word.
      run_prog(core_pcp, 0);
      check("rehalt_strobes", strobe_seen, 0);
      check("rehalt_pcp", core_pcp, 28'd1);

      // Short literal.
      clear_mem();
      mem[0] = 16'h7FFF;
      run_prog(28'd0, 0);
      check("short_push", last_push, 56'h3FFF);
      check("short_count", push_seen, 1);

      // Long-literal header; the tag-11 payload word must be treated as plain data.
      clear_mem();
      mem[0] = 16'h8000;
      mem[1] = 16'h0001;
      mem[2] = 16'hC002;
      mem[3] = 16'h0003;
      mem[4] = 16'h0004;
      run_prog(28'd0, 0);
`ifdef CORE_DISPATCH_LONG_LIT_EN
      lit_ref = {14'h1, 14'h2, 14'h3, 14'h4};
      check("long_push", last_push, lit_ref);
      check("long_latency", first_strobe_cyc, start_cyc + 11);
      check("long_steps", step_seen, 5);
      check("long_pcp", core_pcp, 28'd5);
`else
      lit_ref = '0;
      check("long_fault", fault, 1);
      check("long_no_push", push_seen, 0);
      check("long_pcp", core_pcp, 28'd0);
      check("long_no_push_value", push_value, 56'h3FFF | lit_ref);
`endif

      // Core busy for 20 cycles, then an instruction and a short literal back to back.
      clear_mem();
      mem[0] = 16'h0007;
      mem[1] = 16'h4123;
      run_prog(28'd0, 20);
      check("busy_last_push", last_push, 56'h0123);
      check("busy_last_instr", last_instr, 14'h0007);

      // Fetch address wraps from 15 to 0.
      clear_mem();
      mem[15] = 16'h0042;
      mem[0]  = 16'hC000;
      run_prog(28'd15, 0);
      check("wrap_instr", last_instr, 14'h0042);
      check("wrap_pcp", core_pcp, 28'd16);

      // Reset in the middle of a word with the core busy.
      clear_mem();
`ifdef CORE_DISPATCH_LONG_LIT_EN
      mem[0] = 16'h8000;
      mem[1] = 16'h0011;
      mem[2] = 16'h0022;
      mem[3] = 16'h0033;
      mem[4] = 16'h0044;
`else
      mem[0] = 16'h4005;
`endif
      set_pcp(28'd0);
      build_model(28'd0);
      acore_idle = 1'b0;
      start      = 1'b1;
      tick(1);
      start = 1'b0;
      tick(4);
      check("pre_reset_busy", busy, 1);
      rst = 1'b1;
      tick(1);
      check_reset_state();
      exp_fetch.delete();
      exp_ev.delete();
      fault_exp  = 1'b0;
      rst        = 1'b0;
      acore_idle = 1'b1;
      tick(5);
      check("post_reset_quiet", {busy, mem_rd_en, push_en, instr_en}, 0);

      // Normal operation after reset.
      mem[0] = 16'h0183;
      mem[1] = 16'hC000;
      run_prog(28'd0, 0);
      check("after_reset_instr", last_instr, 14'h0183);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

endmodule
